// File: rtl/mips_md_pkg.sv
// Shared constants and types for the MIPS multiply/divide controller.
// The optional madd family (MD_MADD_EN) uses the SPECIAL2 constants below.
package mips_md_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    localparam logic [5:0] FN_MADD  = 6'b000000;
    localparam logic [5:0] FN_MADDU = 6'b000001;
    localparam logic [5:0] FN_MSUB  = 6'b000100;
    localparam logic [5:0] FN_MSUBU = 6'b000101;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit result of mult/div (and madd family when MD_MADD_EN
// is defined); {hi,lo} ordering of the returned word.
module md_calc
    import mips_md_pkg::*;
(
    input  logic [5:0]  funct_i,
    input  logic        special2_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    input  logic [63:0] hilo_i,
    output logic [63:0] result_o
);

    logic [63:0] prod_s_s;
    logic [63:0] prod_u_s;
    logic [31:0] abs_rs_s;
    logic [31:0] abs_rt_s;
    logic [31:0] sdiv_den_s;
    logic [31:0] udiv_den_s;
    logic [31:0] mag_quo_s;
    logic [31:0] mag_rem_s;
    logic [31:0] squo_s;
    logic [31:0] srem_s;
    logic        rt_zero_s;

    assign prod_s_s = $signed({{32{rs_i[31]}}, rs_i}) * $signed({{32{rt_i[31]}}, rt_i});
    assign prod_u_s = {32'd0, rs_i} * {32'd0, rt_i};

    // Signed divide on magnitudes: avoids host traps on 0x8000_0000 / -1
    // and still yields quotient 0x8000_0000, remainder 0 for that case.
    assign abs_rs_s   = rs_i[31] ? (32'd0 - rs_i) : rs_i;
    assign abs_rt_s   = rt_i[31] ? (32'd0 - rt_i) : rt_i;
    assign rt_zero_s  = (rt_i == 32'd0);
    assign sdiv_den_s = rt_zero_s ? 32'd1 : abs_rt_s;
    assign udiv_den_s = rt_zero_s ? 32'd1 : rt_i;
    assign mag_quo_s  = abs_rs_s / sdiv_den_s;
    assign mag_rem_s  = abs_rs_s % sdiv_den_s;
    assign squo_s     = (rs_i[31] ^ rt_i[31]) ? (32'd0 - mag_quo_s) : mag_quo_s;
    assign srem_s     = rs_i[31] ? (32'd0 - mag_rem_s) : mag_rem_s;

    // Result select by instruction class.
    always_comb begin
        result_o = 64'd0;
        if (special2_i) begin
`ifdef MD_MADD_EN
            case (funct_i)
                FN_MADD:  result_o = hilo_i + prod_s_s;
                FN_MADDU: result_o = hilo_i + prod_u_s;
                FN_MSUB:  result_o = hilo_i - prod_s_s;
                FN_MSUBU: result_o = hilo_i - prod_u_s;
                default:  result_o = hilo_i;
            endcase
`else
            result_o = hilo_i;
`endif
        end else begin
            case (funct_i)
                FN_MULT:  result_o = prod_s_s;
                FN_MULTU: result_o = prod_u_s;
                FN_DIV: begin
                    if (rt_zero_s) begin
                        result_o = {rs_i, DIV0_LO};
                    end else begin
                        result_o = {srem_s, squo_s};
                    end
                end
                FN_DIVU: begin
                    if (rt_zero_s) begin
                        result_o = {rs_i, DIV0_LO};
                    end else begin
                        result_o = {rs_i % udiv_den_s, rs_i / udiv_den_s};
                    end
                end
                default:  result_o = 64'd0;
            endcase
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide controller owning HI/LO, with D-stage stall.
// Define MD_MADD_EN to decode the SPECIAL2 madd/maddu/msub/msubu family.
module muldiv_ctrl
    import mips_md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IR_D,
    input  logic [31:0] IR_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      res_hi_q, res_hi_d;
    logic [31:0]      res_lo_q, res_lo_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [5:0]  op_d_s, fn_d_s, op_e_s, fn_e_s;
    logic        md_d_s, mul_e_s, div_e_s, start_s, busy_s;
    logic        mthi_e_s, mtlo_e_s, special2_e_s;
    logic [63:0] calc_s;
    logic        unused_ir_s;

    assign op_d_s = IR_D[31:26];
    assign fn_d_s = IR_D[5:0];
    assign op_e_s = IR_E[31:26];
    assign fn_e_s = IR_E[5:0];
    assign unused_ir_s = ^{IR_D[25:6], IR_E[25:6]};

    function automatic logic is_madd_fam(input logic [5:0] op, input logic [5:0] fn);
`ifdef MD_MADD_EN
        return (op == OP_SPECIAL2) &&
               ((fn == FN_MADD) || (fn == FN_MADDU) || (fn == FN_MSUB) || (fn == FN_MSUBU));
`else
        return 1'b0 & (^{op, fn});
`endif
    endfunction

    function automatic logic is_mul(input logic [5:0] op, input logic [5:0] fn);
        return ((op == OP_SPECIAL) && ((fn == FN_MULT) || (fn == FN_MULTU))) ||
               is_madd_fam(op, fn);
    endfunction

    function automatic logic is_div(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_SPECIAL) && ((fn == FN_DIV) || (fn == FN_DIVU));
    endfunction

    function automatic logic is_hilo_move(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_SPECIAL) &&
               ((fn == FN_MFHI) || (fn == FN_MTHI) || (fn == FN_MFLO) || (fn == FN_MTLO));
    endfunction

    assign md_d_s       = is_mul(op_d_s, fn_d_s) || is_div(op_d_s, fn_d_s) ||
                          is_hilo_move(op_d_s, fn_d_s);
    assign mul_e_s      = is_mul(op_e_s, fn_e_s);
    assign div_e_s      = is_div(op_e_s, fn_e_s);
    assign busy_s       = (state_q != ST_IDLE);
    assign start_s      = (mul_e_s || div_e_s) && !busy_s;
    assign mthi_e_s     = (op_e_s == OP_SPECIAL) && (fn_e_s == FN_MTHI);
    assign mtlo_e_s     = (op_e_s == OP_SPECIAL) && (fn_e_s == FN_MTLO);
    assign special2_e_s = (op_e_s == OP_SPECIAL2);

    md_calc u_calc (
        .funct_i    (fn_e_s),
        .special2_i (special2_e_s),
        .rs_i       (rs_E),
        .rt_i       (rt_E),
        .hilo_i     ({hi_q, lo_q}),
        .result_o   (calc_s)
    );

    // Next-state: start/latch in IDLE, count down and commit while busy.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d  = mul_e_s ? ST_MUL : ST_DIV;
                    cnt_d    = mul_e_s ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                    res_hi_d = calc_s[63:32];
                    res_lo_d = calc_s[31:0];
                end else if (mthi_e_s) begin
                    hi_d = rs_E;
                end else if (mtlo_e_s) begin
                    lo_d = rs_E;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == '0) begin
                    hi_d    = res_hi_q;
                    lo_d    = res_lo_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, pending result and architectural HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_s;
    assign stall_md = md_d_s && (busy_s || start_s);

endmodule
